// File: rtl/dragonfang_pkg.sv
// dragonfang_pkg: shared limits and operand record for the vector register-read stage.
// Modules carry operands as flattened vectors; vrr_port_t describes one port in the default widths.
package dragonfang_pkg;
    localparam int VRR_MAX_PIPE_STAGES = 3;
    localparam int VRR_TAG_WIDTH       = 5;
    localparam int VRR_VLEN            = 128;
    typedef struct packed {
        logic [VRR_TAG_WIDTH-1:0] tag;
        logic [VRR_VLEN-1:0]      data;
    } vrr_port_t;
endpackage

// File: rtl/vrr_pipe_stage.sv
// vrr_pipe_stage: one operand pipeline register (valid, tags, data) that forwards
// write-back into whatever it captures or holds, so operands never go stale.
module vrr_pipe_stage #(
    parameter int NUM_READ_PORTS = 4,
    parameter int TAG_WIDTH      = 5,
    parameter int VLEN           = 128
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                i_load,
    input  logic                                i_valid,
    input  logic [NUM_READ_PORTS*TAG_WIDTH-1:0] i_tag,
    input  logic [NUM_READ_PORTS*VLEN-1:0]      i_data,
    input  logic                                i_wb_valid,
    input  logic [TAG_WIDTH-1:0]                i_wb_addr,
    input  logic [VLEN-1:0]                     i_wb_data,
    output logic                                o_valid,
    output logic [NUM_READ_PORTS*TAG_WIDTH-1:0] o_tag,
    output logic [NUM_READ_PORTS*VLEN-1:0]      o_data
);
    logic                                r_valid;
    logic [NUM_READ_PORTS*TAG_WIDTH-1:0] r_tag;
    logic [NUM_READ_PORTS*VLEN-1:0]      r_data;
    logic                                w_valid;
    logic [NUM_READ_PORTS*TAG_WIDTH-1:0] w_tag;
    logic [NUM_READ_PORTS*VLEN-1:0]      w_data;
    logic [NUM_READ_PORTS*VLEN-1:0]      w_data_fwd;

    always_comb begin
        w_valid = i_load ? i_valid : r_valid;
        w_tag   = i_load ? i_tag   : r_tag;
        w_data  = i_load ? i_data  : r_data;
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_fwd
        assign w_data_fwd[p*VLEN +: VLEN] =
            (w_valid && i_wb_valid && i_wb_addr == w_tag[p*TAG_WIDTH +: TAG_WIDTH])
            ? i_wb_data : w_data[p*VLEN +: VLEN];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid;
            r_tag   <= w_tag;
            r_data  <= w_data_fwd;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_data  = r_data;
endmodule

// File: rtl/vector_register_read_mp.sv
// vector_register_read_mp: vector register file with multi-port operand read, write-back bypass
// and a valid/ready output pipeline. VECTOR_REGISTER_READ_STALL_COUNT_EN adds o_stall_cycles.
module vector_register_read_mp
    import dragonfang_pkg::*;
#(
    parameter int NUM_READ_PORTS = 4,
    parameter int NUM_REGS       = 32,
    parameter int TAG_WIDTH      = 5,
    parameter int VLEN           = 128,
    parameter int PIPE_STAGES    = 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                i_in_valid,
    output logic                                o_in_ready,
    input  logic [NUM_READ_PORTS*TAG_WIDTH-1:0] i_rd_addr,
    input  logic                                i_wb_valid,
    input  logic [TAG_WIDTH-1:0]                i_wb_addr,
    input  logic [VLEN-1:0]                     i_wb_data,
    output logic                                o_out_valid,
    input  logic                                i_out_ready,
    output logic [NUM_READ_PORTS*VLEN-1:0]      o_rd_data,
    output logic [NUM_READ_PORTS*TAG_WIDTH-1:0] o_rd_tag
`ifdef VECTOR_REGISTER_READ_STALL_COUNT_EN
   ,output logic [31:0]                         o_stall_cycles
`endif
);
    localparam int NT = NUM_READ_PORTS*TAG_WIDTH;
    localparam int ND = NUM_READ_PORTS*VLEN;

    if (PIPE_STAGES < 1 || PIPE_STAGES > VRR_MAX_PIPE_STAGES) begin : g_bad_stages
        $error("vector_register_read_mp: PIPE_STAGES=%0d outside 1..%0d", PIPE_STAGES, VRR_MAX_PIPE_STAGES);
    end
    if (TAG_WIDTH != $clog2(NUM_REGS)) begin : g_bad_tag
        $error("vector_register_read_mp: TAG_WIDTH must equal $clog2(NUM_REGS)");
    end

    logic [VLEN-1:0] r_regs [NUM_REGS];
    logic            w_advance;
    logic [ND-1:0]   w_rf_data;
    logic            w_valid [PIPE_STAGES+1];
    logic [NT-1:0]   w_tag   [PIPE_STAGES+1];
    logic [ND-1:0]   w_data  [PIPE_STAGES+1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
        end else if (i_wb_valid) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        assign w_rf_data[p*VLEN +: VLEN] = r_regs[i_rd_addr[p*TAG_WIDTH +: TAG_WIDTH]];
    end

    assign w_advance  = !o_out_valid || i_out_ready;
    assign o_in_ready = w_advance;
    assign w_valid[0] = i_in_valid;
    assign w_tag[0]   = i_rd_addr;
    assign w_data[0]  = w_rf_data;

    // Same-cycle bypass happens inside stage 0, which forwards into what it captures.
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        vrr_pipe_stage #(
            .NUM_READ_PORTS(NUM_READ_PORTS),
            .TAG_WIDTH     (TAG_WIDTH),
            .VLEN          (VLEN)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .i_load    (w_advance),
            .i_valid   (w_valid[s]),
            .i_tag     (w_tag[s]),
            .i_data    (w_data[s]),
            .i_wb_valid(i_wb_valid),
            .i_wb_addr (i_wb_addr),
            .i_wb_data (i_wb_data),
            .o_valid   (w_valid[s+1]),
            .o_tag     (w_tag[s+1]),
            .o_data    (w_data[s+1])
        );
    end

    assign o_out_valid = w_valid[PIPE_STAGES];
    assign o_rd_tag    = w_tag[PIPE_STAGES];
    assign o_rd_data   = w_data[PIPE_STAGES];

`ifdef VECTOR_REGISTER_READ_STALL_COUNT_EN
    logic [31:0] r_stall_cycles;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (o_out_valid && !i_out_ready && r_stall_cycles != 32'hFFFF_FFFF) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end
    assign o_stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_vector_register_read_mp.sv
// tb_vector_register_read_mp: drives a 1-stage and a 3-stage instance with the same stimulus
// and checks both against a regfile-plus-slot model every cycle, plus literal checkpoints.
module tb_vector_register_read_mp;
    localparam int NP = 4;
    localparam int TW = 5;
    localparam int VL = 128;
    localparam logic [VL-1:0] A5   = {16{8'hA5}};
    localparam logic [VL-1:0] ONES = {VL{1'b1}};
    localparam logic [VL-1:0] ZERO = {VL{1'b0}};

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic               in_valid = 1'b0;
    logic               wb_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic [NP*TW-1:0]   rd_addr = '0;
    logic [TW-1:0]      wb_addr = '0;
    logic [VL-1:0]      wb_data = '0;
    logic               in_ready  [2];
    logic               out_valid [2];
    logic [NP*VL-1:0]   rd_data   [2];
    logic [NP*TW-1:0]   rd_tag    [2];
`ifdef VECTOR_REGISTER_READ_STALL_COUNT_EN
    logic [31:0]        stall     [2];
`endif

    int checks = 0;
    int errors = 0;

    vector_register_read_mp #(.PIPE_STAGES(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready[0]), .i_rd_addr(rd_addr),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready),
        .o_rd_data(rd_data[0]), .o_rd_tag(rd_tag[0])
`ifdef VECTOR_REGISTER_READ_STALL_COUNT_EN
       ,.o_stall_cycles(stall[0])
`endif
    );

    vector_register_read_mp #(.PIPE_STAGES(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready[1]), .i_rd_addr(rd_addr),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready),
        .o_rd_data(rd_data[1]), .o_rd_tag(rd_tag[1])
`ifdef VECTOR_REGISTER_READ_STALL_COUNT_EN
       ,.o_stall_cycles(stall[1])
`endif
    );

    task automatic chk(input string name, input logic [NP*VL-1:0] act, input logic [NP*VL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int depth(input int d);
        return d == 0 ? 1 : 3;
    endfunction

    // Model: the architectural register file plus, per instance, the requests occupying each
    // pipeline slot. A valid output must carry the current file contents of its tags.
    logic [VL-1:0]    m_rf [32]   = '{default: '0};
    bit               m_v  [2][3] = '{default: 1'b0};
    logic [NP*TW-1:0] m_t  [2][3] = '{default: '0};
    logic [31:0]      m_sc [2]    = '{default: '0};

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_rf = '{default: '0};
            m_v  = '{default: 1'b0};
            m_t  = '{default: '0};
            m_sc = '{default: '0};
        end else begin
            for (int d = 0; d < 2; d++) begin
                int l;
                l = depth(d) - 1;
                if (m_v[d][l] && !out_ready && m_sc[d] != 32'hFFFF_FFFF) m_sc[d] = m_sc[d] + 1;
                if (!m_v[d][l] || out_ready) begin
                    for (int k = l; k > 0; k--) begin
                        m_v[d][k] = m_v[d][k-1];
                        m_t[d][k] = m_t[d][k-1];
                    end
                    m_v[d][0] = in_valid;
                    m_t[d][0] = rd_addr;
                end
            end
            if (wb_valid) m_rf[wb_addr] = wb_data;
        end
    end

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            int l;
            l = depth(d) - 1;
            chk($sformatf("d%0d out_valid", d), NP*VL'(out_valid[d]), NP*VL'(m_v[d][l]));
            chk($sformatf("d%0d in_ready", d), NP*VL'(in_ready[d]), NP*VL'(!m_v[d][l] || out_ready));
`ifdef VECTOR_REGISTER_READ_STALL_COUNT_EN
            chk($sformatf("d%0d stall_cycles", d), NP*VL'(stall[d]), NP*VL'(m_sc[d]));
`endif
            if (!reset_n) begin
                chk($sformatf("d%0d rd_data in reset", d), rd_data[d], '0);
            end else if (m_v[d][l]) begin
                chk($sformatf("d%0d rd_tag", d), NP*VL'(rd_tag[d]), NP*VL'(m_t[d][l]));
                for (int p = 0; p < NP; p++)
                    chk($sformatf("d%0d rd_data port%0d", d, p), NP*VL'(rd_data[d][p*VL +: VL]),
                        NP*VL'(m_rf[m_t[d][l][p*TW +: TW]]));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #12;
        chk("reset out_valid d1", NP*VL'(out_valid[0]), '0);
        chk("reset out_valid d3", NP*VL'(out_valid[1]), '0);
        chk("reset rd_data d1", rd_data[0], '0);
        chk("reset rd_tag d1", NP*VL'(rd_tag[0]), '0);
        reset_n = 1'b1;
        tick();

        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = A5;
        tick();
        wb_valid = 1'b0;
        rd_addr = {5'd3, 5'd3, 5'd0, 5'd1}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("basic out_valid", NP*VL'(out_valid[0]), NP*VL'(1'b1));
        chk("basic rd_data", rd_data[0], {A5, A5, ZERO, ZERO});

        rd_addr = {5'd0, 5'd5, 5'd0, 5'd0}; in_valid = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = VL'(16'h1234);
        tick();
        in_valid = 1'b0; wb_valid = 1'b0;
        chk("bypass port2", NP*VL'(rd_data[0][2*VL +: VL]), NP*VL'(16'h1234));
        repeat (3) tick();

        for (int k = 1; k <= 4; k++) begin
            wb_valid = 1'b1; wb_addr = TW'(k); wb_data = {16{8'(k)}};
            tick();
        end
        wb_valid = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            in_valid = (n <= 4);
            rd_addr = {NP{TW'(n)}};
            tick();
            chk($sformatf("depth3 out_valid c%0d", n), NP*VL'(out_valid[1]), NP*VL'(n >= 3));
            if (n >= 3) begin
                chk($sformatf("depth3 order c%0d", n), NP*VL'(rd_tag[1][TW-1:0]), NP*VL'(n - 2));
                chk($sformatf("depth3 data c%0d", n), NP*VL'(rd_data[1][VL-1:0]), NP*VL'({16{8'(n - 2)}}));
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();

        rd_addr = {NP{5'd7}}; in_valid = 1'b1;
        tick();
        out_ready = 1'b0; rd_addr = {NP{5'd9}};
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("stall in_ready c%0d", c), NP*VL'(in_ready[0]), '0);
            chk($sformatf("stall rd_tag c%0d", c), NP*VL'(rd_tag[0]), NP*VL'({NP{5'd7}}));
        end
`ifdef VECTOR_REGISTER_READ_STALL_COUNT_EN
        chk("stall_cycles after 5", NP*VL'(stall[0]), NP*VL'(5));
`endif
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = ONES;
        tick();
        wb_valid = 1'b0;
        chk("held forward data", rd_data[0], {NP{ONES}});
        chk("held forward tag", NP*VL'(rd_tag[0]), NP*VL'({NP{5'd7}}));
        chk("held in_ready", NP*VL'(in_ready[0]), '0);

        #2 reset_n = 1'b0;
        #1;
        chk("async reset out_valid", NP*VL'(out_valid[0]), '0);
        chk("async reset rd_data", rd_data[0], '0);
`ifdef VECTOR_REGISTER_READ_STALL_COUNT_EN
        chk("async reset stall_cycles", NP*VL'(stall[0]), '0);
`endif
        @(negedge clock);
        #1;
        reset_n = 1'b1; out_ready = 1'b1;
        rd_addr = {NP{5'd7}}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post reset out_valid", NP*VL'(out_valid[0]), NP*VL'(1'b1));
        chk("post reset read", rd_data[0], '0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
